control_rx_kernel_dispatcher: RTL and testbench
===============================================

Name: control_rx_kernel_dispatcher

Overview:
- Sits directly downstream of the control RX network bridge.
- Consumes its single-beat control messages (data, keep, tid, tdest, tuser).
- Buffers them in a small FIFO and presents them to the kernel-side control interconnect.
- Drops malformed or unroutable messages, with drop counters and sticky error flags for the control API status registers.

Parameters:
AXIS_DATA_WIDTH, 64, message payload width
AXIS_KEEP_WIDTH, 8, AXIS_DATA_WIDTH/8
AXIS_ID_WIDTH, 8, width of tid and tdest
AXIS_TUSER_WIDTH, 64, {src_port[63:48], dest_port[47:32], src_ip[31:0]}
NUM_KERNELS, 16, valid tdest range 0..NUM_KERNELS-1
FIFO_DEPTH, 8, message slots; power of two, >=2
CNT_WIDTH, 16, statistics counter width

Ports:
i_clk  in  1  clock
i_ap_rst_n  in  1  reset, asynchronous, active-low
from_bridge_tvalid  in  1  message valid
from_bridge_tready  out  1  message accepted
from_bridge_tdata  in  AXIS_DATA_WIDTH  payload
from_bridge_tkeep  in  AXIS_KEEP_WIDTH  byte enables
from_bridge_tid  in  AXIS_ID_WIDTH  sender kernel id
from_bridge_tdest  in  AXIS_ID_WIDTH  destination kernel id
from_bridge_tuser  in  AXIS_TUSER_WIDTH  src ip/ports
from_bridge_tlast  in  1  must be 1 (single-beat messages)
to_kernel_tvalid  out  1  message valid
to_kernel_tready  in  1  consumer ready
to_kernel_tdata  out  AXIS_DATA_WIDTH  payload
to_kernel_tkeep  out  AXIS_KEEP_WIDTH  byte enables
to_kernel_tid  out  AXIS_ID_WIDTH  sender id
to_kernel_tdest  out  AXIS_ID_WIDTH  destination kernel id
to_kernel_tuser  out  AXIS_TUSER_WIDTH  src ip/ports
to_kernel_tlast  out  1  constant 1
i_clear_stats  in  1  synchronous clear of counters and flags
o_rx_count  out  CNT_WIDTH  messages forwarded into FIFO; wraps
o_drop_count  out  CNT_WIDTH  messages dropped; saturates at all-ones
o_err_flags  out  2  sticky: [0] tdest out of range, [1] tlast==0
o_occupancy  out  $clog2(FIFO_DEPTH)+1  FIFO fill level

Behaviour:
- Reset (async assert, sync deassert):
  - FIFO empty; to_kernel_tvalid=0; o_occupancy=0.
  - Counters and flags 0.
  - to_kernel data fields 0 while empty.
  - from_bridge_tready=1.
- Accept: from_bridge_tready = (occupancy != FIFO_DEPTH). Registered function of state only; never depends on tvalid or tdata. A message is accepted on tvalid && tready.
- Classification of an accepted message:
  - tdest >= NUM_KERNELS: drop; set err[0]; increment o_drop_count.
  - tlast==0: drop; set err[1]; increment o_drop_count.
  - Both conditions true: drop once; set both flags; o_drop_count increments by 1.
  - Otherwise: push {data, keep, tid, tdest, tuser} into FIFO; increment o_rx_count.
- Output:
  - First-word-fall-through. to_kernel_tvalid = (occupancy != 0).
  - Fields show the head entry; zero when empty.
  - Pop on to_kernel_tvalid && to_kernel_tready.
  - Output fields are stable while tvalid && !tready.
- Latency: message accepted at edge N → to_kernel_tvalid high after edge N (visible in cycle N+1); no same-cycle bypass.
- Simultaneous push and pop: occupancy unchanged; pointers both advance.
- Full:
  - tready=0 even if the consumer pops in the same cycle; it re-opens the next cycle.
  - Messages that will be dropped are also stalled while full, so drop behaviour is independent of back-pressure.
- Empty: pop ignored (tvalid is 0).
- Pointers: log2(FIFO_DEPTH) bits, natural wrap.
- Occupancy: separate counter, range 0..FIFO_DEPTH.
- Counters:
  - o_drop_count saturates at 2^CNT_WIDTH-1.
  - o_rx_count wraps to 0.
  - i_clear_stats zeroes counters and flags.
  - If i_clear_stats coincides with an increment event: clear wins; the event is not counted. Flags are likewise cleared.
- Reset mid-operation: FIFO contents are discarded; the message in flight is lost; no partial output.

Decomposition:
- Package ctrl_api_pkg holds:
  - Widths: AXIS_ID_WIDTH, AXIS_TUSER_WIDTH.
  - TUSER field offsets: SRC_IP 0/32, DEST_PORT 32/16, SRC_PORT 48/16.
  - Packed struct ctrl_msg_t {data, keep, tid, tdest, tuser}, used as the FIFO word.
  - Error-flag bit indices.
- Sub-module: ctrl_msg_fifo, a generic synchronous FWFT FIFO with full/empty/occupancy, parameterised on word width and depth.
- Classification, counters and flags stay in the top.

Test Plan:
- Reset → tready=1, tvalid=0, counters 0.
- One message (tdest=3, tid=5, data=0xDEADBEEF, tlast=1) → next cycle to_kernel_tvalid=1 with identical fields; o_rx_count=1.
- tdest=16 (NUM_KERNELS=16) → nothing output; o_drop_count=1, err=2'b01.
- tlast=0 with tdest=20 → o_drop_count increments by exactly 1; err=2'b11.
- Hold to_kernel_tready=0 and send 9 valid messages → 8 accepted; tready=0 after the 8th; occupancy=8.
- Then assert tready for one cycle with tvalid held → entry 0 popped, tready=1 the next cycle; data order preserved 0..8.
- Continuous tvalid and tready → one message per cycle, occupancy stays 1.
- Preload o_drop_count to all-ones via 65535 drops, then drop one more → count stays 0xFFFF.
- i_clear_stats coincident with a drop → count=0, flags=0.

Source files
------------

// File: rtl/ctrl_api_pkg.sv
// Shared types and constants for the control-message path between the RX bridge and the kernels.
// The FIFO word is the packed message struct; tuser field offsets describe the bridge's source info.
package ctrl_api_pkg;

  localparam int MSG_DATA_WIDTH   = 64;
  localparam int MSG_KEEP_WIDTH   = 8;
  localparam int AXIS_ID_WIDTH    = 8;
  localparam int AXIS_TUSER_WIDTH = 64;

  localparam int SRC_IP_LSB      = 0;
  localparam int SRC_IP_WIDTH    = 32;
  localparam int DEST_PORT_LSB   = 32;
  localparam int DEST_PORT_WIDTH = 16;
  localparam int SRC_PORT_LSB    = 48;
  localparam int SRC_PORT_WIDTH  = 16;

  localparam int ERR_WIDTH    = 2;
  localparam int ERR_BAD_DEST = 0;
  localparam int ERR_NO_LAST  = 1;

  typedef struct packed {
    logic [MSG_DATA_WIDTH-1:0]   data;
    logic [MSG_KEEP_WIDTH-1:0]   keep;
    logic [AXIS_ID_WIDTH-1:0]    tid;
    logic [AXIS_ID_WIDTH-1:0]    tdest;
    logic [AXIS_TUSER_WIDTH-1:0] tuser;
  } ctrl_msg_t;

  function automatic logic [AXIS_TUSER_WIDTH-1:0] make_tuser(
    input logic [SRC_PORT_WIDTH-1:0]  src_port,
    input logic [DEST_PORT_WIDTH-1:0] dest_port,
    input logic [SRC_IP_WIDTH-1:0]    src_ip
  );
    logic [AXIS_TUSER_WIDTH-1:0] t;
    t = '0;
    t[SRC_IP_LSB +: SRC_IP_WIDTH]       = src_ip;
    t[DEST_PORT_LSB +: DEST_PORT_WIDTH] = dest_port;
    t[SRC_PORT_LSB +: SRC_PORT_WIDTH]   = src_port;
    return t;
  endfunction

endpackage

// File: rtl/ctrl_msg_fifo.sv
// Generic first-word-fall-through FIFO with a separate occupancy counter.
// The head word reads as zero while empty; push when full and pop when empty are ignored.
module ctrl_msg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (occupancy == OCC_W'(DEPTH));
  assign empty    = (occupancy == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset: an empty FIFO masks whatever the array holds.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/control_rx_kernel_dispatcher.sv
// Buffers single-beat control messages from the RX bridge for the kernel interconnect,
// dropping unroutable or multi-beat messages and keeping drop statistics and sticky error flags.
module control_rx_kernel_dispatcher #(
  parameter int AXIS_DATA_WIDTH  = 64,
  parameter int AXIS_KEEP_WIDTH  = 8,
  parameter int AXIS_ID_WIDTH    = 8,
  parameter int AXIS_TUSER_WIDTH = 64,
  parameter int NUM_KERNELS      = 16,
  parameter int FIFO_DEPTH       = 8,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                          i_clk,
  input  logic                          i_ap_rst_n,
  input  logic                          from_bridge_tvalid,
  output logic                          from_bridge_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]    from_bridge_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]    from_bridge_tkeep,
  input  logic [AXIS_ID_WIDTH-1:0]      from_bridge_tid,
  input  logic [AXIS_ID_WIDTH-1:0]      from_bridge_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0]   from_bridge_tuser,
  input  logic                          from_bridge_tlast,
  output logic                          to_kernel_tvalid,
  input  logic                          to_kernel_tready,
  output logic [AXIS_DATA_WIDTH-1:0]    to_kernel_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]    to_kernel_tkeep,
  output logic [AXIS_ID_WIDTH-1:0]      to_kernel_tid,
  output logic [AXIS_ID_WIDTH-1:0]      to_kernel_tdest,
  output logic [AXIS_TUSER_WIDTH-1:0]   to_kernel_tuser,
  output logic                          to_kernel_tlast,
  input  logic                          i_clear_stats,
  output logic [CNT_WIDTH-1:0]          o_rx_count,
  output logic [CNT_WIDTH-1:0]          o_drop_count,
  output logic [1:0]                    o_err_flags,
  output logic [$clog2(FIFO_DEPTH):0]   o_occupancy
);

  import ctrl_api_pkg::*;

  ctrl_msg_t msg_in;
  ctrl_msg_t msg_head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      accept;
  logic      bad_dest;
  logic      no_last;
  logic      push;
  logic      drop;
  logic      pop;

  // Handshakes: a beat transfers on the edge where valid && ready are both high.
  // Ready here depends only on FIFO state, so malformed messages stall while full too.
  assign from_bridge_tready = !fifo_full;
  assign accept             = from_bridge_tvalid && from_bridge_tready;
  assign bad_dest           = 32'(from_bridge_tdest) >= NUM_KERNELS;
  assign no_last            = !from_bridge_tlast;
  assign drop               = accept && (bad_dest || no_last);
  assign push               = accept && !bad_dest && !no_last;
  assign pop                = to_kernel_tvalid && to_kernel_tready;

  assign msg_in.data  = from_bridge_tdata;
  assign msg_in.keep  = from_bridge_tkeep;
  assign msg_in.tid   = from_bridge_tid;
  assign msg_in.tdest = from_bridge_tdest;
  assign msg_in.tuser = from_bridge_tuser;

  ctrl_msg_fifo #(
    .WIDTH ($bits(ctrl_msg_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_ap_rst_n),
    .push      (push),
    .push_data (msg_in),
    .pop       (pop),
    .pop_data  (msg_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (o_occupancy)
  );

  assign to_kernel_tvalid = !fifo_empty;
  assign to_kernel_tdata  = msg_head.data;
  assign to_kernel_tkeep  = msg_head.keep;
  assign to_kernel_tid    = msg_head.tid;
  assign to_kernel_tdest  = msg_head.tdest;
  assign to_kernel_tuser  = msg_head.tuser;
  assign to_kernel_tlast  = 1'b1;

  // A clear in the same cycle as an event wins; the event is not recorded.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      o_rx_count   <= '0;
      o_drop_count <= '0;
      o_err_flags  <= '0;
    end else if (i_clear_stats) begin
      o_rx_count   <= '0;
      o_drop_count <= '0;
      o_err_flags  <= '0;
    end else begin
      if (push) o_rx_count <= o_rx_count + 1'b1;
      if (drop && (o_drop_count != '1)) o_drop_count <= o_drop_count + 1'b1;
      if (accept && bad_dest) o_err_flags[ERR_BAD_DEST] <= 1'b1;
      if (accept && no_last)  o_err_flags[ERR_NO_LAST]  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_control_rx_kernel_dispatcher.sv
// Directed bench for control_rx_kernel_dispatcher: routing, drops, back-pressure, FWFT order,
// counter saturation and clear priority, and reset mid-operation.
module tb_control_rx_kernel_dispatcher;
  import ctrl_api_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        b_tvalid;
  logic        b_tready;
  logic [63:0] b_tdata;
  logic [7:0]  b_tkeep;
  logic [7:0]  b_tid;
  logic [7:0]  b_tdest;
  logic [63:0] b_tuser;
  logic        b_tlast;
  logic        k_tvalid;
  logic        k_tready;
  logic [63:0] k_tdata;
  logic [7:0]  k_tkeep;
  logic [7:0]  k_tid;
  logic [7:0]  k_tdest;
  logic [63:0] k_tuser;
  logic        k_tlast;
  logic        clear_stats;
  logic [15:0] rx_count;
  logic [15:0] drop_count;
  logic [1:0]  err_flags;
  logic [3:0]  occupancy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_word;
  logic [63:0] tuser_a;

  control_rx_kernel_dispatcher dut (
    .i_clk              (clk),
    .i_ap_rst_n         (rst_n),
    .from_bridge_tvalid (b_tvalid),
    .from_bridge_tready (b_tready),
    .from_bridge_tdata  (b_tdata),
    .from_bridge_tkeep  (b_tkeep),
    .from_bridge_tid    (b_tid),
    .from_bridge_tdest  (b_tdest),
    .from_bridge_tuser  (b_tuser),
    .from_bridge_tlast  (b_tlast),
    .to_kernel_tvalid   (k_tvalid),
    .to_kernel_tready   (k_tready),
    .to_kernel_tdata    (k_tdata),
    .to_kernel_tkeep    (k_tkeep),
    .to_kernel_tid      (k_tid),
    .to_kernel_tdest    (k_tdest),
    .to_kernel_tuser    (k_tuser),
    .to_kernel_tlast    (k_tlast),
    .i_clear_stats      (clear_stats),
    .o_rx_count         (rx_count),
    .o_drop_count       (drop_count),
    .o_err_flags        (err_flags),
    .o_occupancy        (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive_msg(input logic [63:0] data, input logic [7:0] tdest, input logic last);
    b_tvalid = 1'b1;
    b_tdata  = data;
    b_tkeep  = 8'hFF;
    b_tid    = 8'd5;
    b_tdest  = tdest;
    b_tuser  = tuser_a;
    b_tlast  = last;
  endtask

  initial begin
    tuser_a     = make_tuser(16'h1234, 16'h5678, 32'hC0A8_0001);
    rst_n       = 1'b0;
    b_tvalid    = 1'b0;
    b_tdata     = '0;
    b_tkeep     = '0;
    b_tid       = '0;
    b_tdest     = '0;
    b_tuser     = '0;
    b_tlast     = 1'b0;
    k_tready    = 1'b0;
    clear_stats = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    check("rst_tready", 64'(b_tready), 64'd1);
    check("rst_tvalid", 64'(k_tvalid), 64'd0);
    check("rst_rx", 64'(rx_count), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_err", 64'(err_flags), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_tdata", k_tdata, 64'd0);

    // single good message
    drive_msg(64'hDEAD_BEEF, 8'd3, 1'b1);
    step();
    b_tvalid = 1'b0;
    check("msg_tvalid", 64'(k_tvalid), 64'd1);
    check("msg_tdata", k_tdata, 64'hDEAD_BEEF);
    check("msg_tkeep", 64'(k_tkeep), 64'hFF);
    check("msg_tid", 64'(k_tid), 64'd5);
    check("msg_tdest", 64'(k_tdest), 64'd3);
    check("msg_tuser", k_tuser, 64'h1234_5678_C0A8_0001);
    check("msg_tlast", 64'(k_tlast), 64'd1);
    check("msg_rx", 64'(rx_count), 64'd1);
    check("msg_occ", 64'(occupancy), 64'd1);
    k_tready = 1'b1;
    step();
    k_tready = 1'b0;
    check("pop_tvalid", 64'(k_tvalid), 64'd0);
    check("pop_tdata_zero", k_tdata, 64'd0);

    // out-of-range tdest
    drive_msg(64'h1111, 8'd16, 1'b1);
    step();
    b_tvalid = 1'b0;
    check("bad_dest_tvalid", 64'(k_tvalid), 64'd0);
    check("bad_dest_drop", 64'(drop_count), 64'd1);
    check("bad_dest_err", 64'(err_flags), 64'b01);
    check("bad_dest_rx", 64'(rx_count), 64'd1);

    // both faults: single drop
    drive_msg(64'h2222, 8'd20, 1'b0);
    step();
    b_tvalid = 1'b0;
    check("both_drop", 64'(drop_count), 64'd2);
    check("both_err", 64'(err_flags), 64'b11);
    check("both_occ", 64'(occupancy), 64'd0);

    // fill under back-pressure: 9 offered, 8 accepted
    for (int i = 0; i < 9; i++) begin
      drive_msg(64'(i), 8'd1, 1'b1);
      check("fill_tready", 64'(b_tready), (i < 8) ? 64'd1 : 64'd0);
      if (i < 8) exp_q.push_back(64'(i));
      if (i < 8) step();
    end
    check("full_occ", 64'(occupancy), 64'd8);
    check("full_rx", 64'(rx_count), 64'd9);
    check("full_tready", 64'(b_tready), 64'd0);
    exp_word = exp_q.pop_front();
    check("full_head", k_tdata, exp_word);
    k_tready = 1'b1;
    step();
    k_tready = 1'b0;
    check("reopen_occ", 64'(occupancy), 64'd7);
    check("reopen_tready", 64'(b_tready), 64'd1);
    step();
    b_tvalid = 1'b0;
    exp_q.push_back(64'd8);
    check("refill_occ", 64'(occupancy), 64'd8);
    k_tready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      exp_word = exp_q.pop_front();
      check("drain_tvalid", 64'(k_tvalid), 64'd1);
      check("drain_order", k_tdata, exp_word);
      step();
    end
    check("drain_empty", 64'(k_tvalid), 64'd0);

    // streaming at full rate
    for (int k = 0; k < 6; k++) begin
      drive_msg(64'(100 + k), 8'd15, 1'b1);
      step();
      check("stream_occ", 64'(occupancy), 64'd1);
      check("stream_data", k_tdata, 64'(100 + k));
    end
    b_tvalid = 1'b0;
    step();
    k_tready = 1'b0;
    check("stream_end_occ", 64'(occupancy), 64'd0);
    check("stream_rx", 64'(rx_count), 64'd16);

    // plain clear
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    check("clr_rx", 64'(rx_count), 64'd0);
    check("clr_drop", 64'(drop_count), 64'd0);
    check("clr_err", 64'(err_flags), 64'd0);

    // drop counter saturation
    drive_msg(64'h3333, 8'd16, 1'b1);
    repeat (65535) step();
    check("sat_preload", 64'(drop_count), 64'hFFFF);
    step();
    b_tvalid = 1'b0;
    check("sat_hold", 64'(drop_count), 64'hFFFF);
    check("sat_err", 64'(err_flags), 64'b01);

    // clear coincident with a drop
    drive_msg(64'h4444, 8'd16, 1'b0);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    b_tvalid    = 1'b0;
    check("clr_drop_cnt", 64'(drop_count), 64'd0);
    check("clr_drop_err", 64'(err_flags), 64'd0);

    // reset mid-operation
    drive_msg(64'h5555, 8'd2, 1'b1);
    step();
    step();
    b_tvalid = 1'b0;
    check("pre_rst_occ", 64'(occupancy), 64'd2);
    rst_n = 1'b0;
    #2;
    check("mid_rst_tvalid", 64'(k_tvalid), 64'd0);
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_tdata", k_tdata, 64'd0);
    check("mid_rst_rx", 64'(rx_count), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_tvalid", 64'(k_tvalid), 64'd0);
    check("post_rst_tready", 64'(b_tready), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
